// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : Memory-to-writeback pipeline register for the RV32I core.
//               Selects the ALU result, the extracted load value or PC+4,
//               registers it for the reg_file write port, suppresses x0
//               writes and counts retired instructions. All outputs come
//               straight from registers (or a small AND of registers), so
//               they settle well before reg_file's negedge write.
// Ports       : clk, rst_n (sync, active low), stall, flush
//               in_valid, in_reg_write, in_rd, in_result_src, in_funct3,
//               in_alu_result, in_mem_rdata, in_pc_plus4     -> stage inputs
//               wb_valid, write_enable, wb_rd, wb_data        -> reg_file / fwd
//               load_fault                                    -> illegal load
//               retired_count                                 -> retire counter
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_reg_write,
    input  logic [4:0]       in_rd,
    input  logic [1:0]       in_result_src,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic [XLEN-1:0]  in_mem_rdata,
    input  logic [XLEN-1:0]  in_pc_plus4,
    output logic             wb_valid,
    output logic             write_enable,
    output logic [4:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic             load_fault,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [1:0] c_SRC_ALU  = 2'b00;
    localparam logic [1:0] c_SRC_LOAD = 2'b01;
    localparam logic [1:0] c_SRC_PC4  = 2'b10;

    localparam logic [2:0] c_LB  = 3'b000;
    localparam logic [2:0] c_LH  = 3'b001;
    localparam logic [2:0] c_LW  = 3'b010;
    localparam logic [2:0] c_LBU = 3'b100;
    localparam logic [2:0] c_LHU = 3'b101;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_valid;
    logic             r_reg_write;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_data;
    logic             r_fault;
    logic [CNT_W-1:0] r_count;

    logic [1:0]       w_off;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [XLEN-1:0]  w_load_data;
    logic             w_load_illegal;
    logic [XLEN-1:0]  w_result;
    logic             w_fault;

    // Byte lane from the full offset; half lane from off[1] only, so an odd
    // halfword offset silently reads the containing aligned half.
    assign w_off  = in_alu_result[1:0];
    assign w_byte = in_mem_rdata[{w_off, 3'b000} +: 8];
    assign w_half = in_mem_rdata[{w_off[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data    = '0;
        w_load_illegal = 1'b0;
        case (in_funct3)
            c_LB:    w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            c_LH:    w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            c_LW:    w_load_data = in_mem_rdata;
            c_LBU:   w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            c_LHU:   w_load_data = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_result = '0;
        w_fault  = 1'b0;
        case (in_result_src)
            c_SRC_ALU:  w_result = in_alu_result;
            c_SRC_LOAD: begin
                w_result = w_load_data;
                w_fault  = w_load_illegal;
            end
            c_SRC_PC4:  w_result = in_pc_plus4;
            default:    w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_rd        <= '0;
            r_data      <= '0;
            r_fault     <= 1'b0;
            r_count     <= '0;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_rd        <= '0;
            r_data      <= '0;
            r_fault     <= 1'b0;
        end else if (!stall) begin
            r_valid     <= in_valid;
            r_reg_write <= in_reg_write;
            r_rd        <= in_rd;
            r_data      <= w_result;
            r_fault     <= w_fault;
            if (in_valid) begin
                r_count <= r_count + c_CNT_ONE;
            end
        end
    end

    // A faulting load never reaches the register file; neither does x0.
    assign write_enable  = r_valid & r_reg_write & (r_rd != 5'd0) & ~r_fault;
    assign wb_valid      = r_valid;
    assign wb_rd         = r_rd;
    assign wb_data       = r_data;
    assign load_fault    = r_fault;
    assign retired_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage: directed vector table,
//               stall/flush and counter-wrap sequences, then randomized
//               traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic             flush;
    logic             in_valid;
    logic             in_reg_write;
    logic [4:0]       in_rd;
    logic [1:0]       in_result_src;
    logic [2:0]       in_funct3;
    logic [XLEN-1:0]  in_alu_result;
    logic [XLEN-1:0]  in_mem_rdata;
    logic [XLEN-1:0]  in_pc_plus4;
    logic             wb_valid;
    logic             write_enable;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             load_fault;
    logic [CNT_W-1:0] retired_count;

    mem_wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_reg_write  (in_reg_write),
        .in_rd         (in_rd),
        .in_result_src (in_result_src),
        .in_funct3     (in_funct3),
        .in_alu_result (in_alu_result),
        .in_mem_rdata  (in_mem_rdata),
        .in_pc_plus4   (in_pc_plus4),
        .wb_valid      (wb_valid),
        .write_enable  (write_enable),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .load_fault    (load_fault),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit        m_valid;
    bit        m_rw;
    bit [4:0]  m_rd;
    bit [31:0] m_data;
    bit        m_fault;
    int        m_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Load value computed from the ISA definition with shifts and masks.
    function automatic bit [31:0] ref_result(input bit [1:0] src, input bit [2:0] f3,
                                             input bit [31:0] addr, input bit [31:0] word,
                                             input bit [31:0] pc4, output bit fault);
        int unsigned b;
        int unsigned h;
        fault = 0;
        b = (word >> (8 * addr[1:0])) & 32'hFF;
        h = (word >> (16 * (addr[1:0] / 2))) & 32'hFFFF;
        if (src == 2'd0) return addr;
        if (src == 2'd2) return pc4;
        if (src == 2'd3) return 0;
        case (f3)
            3'd0: return (b >= 128) ? b - 256 : b;
            3'd1: return (h >= 32768) ? h - 65536 : h;
            3'd2: return word;
            3'd4: return b;
            3'd5: return h;
            default: begin
                fault = 1;
                return 0;
            end
        endcase
    endfunction

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_step();
        bit        f;
        bit [31:0] r;
        r = ref_result(in_result_src, in_funct3, in_alu_result, in_mem_rdata, in_pc_plus4, f);
        if (!rst_n) begin
            m_valid = 0; m_rw = 0; m_rd = 0; m_data = 0; m_fault = 0; m_count = 0;
        end else if (flush) begin
            m_valid = 0; m_rw = 0; m_rd = 0; m_data = 0; m_fault = 0;
        end else if (!stall) begin
            m_valid = in_valid;
            m_rw    = in_reg_write;
            m_rd    = in_rd;
            m_data  = r;
            m_fault = f;
            if (in_valid) m_count = (m_count + 1) % (1 << CNT_W);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        bit exp_we;
        exp_we = m_valid && m_rw && (m_rd != 0) && !m_fault;
        chk({tag, ".wb_valid"}, wb_valid, m_valid);
        chk({tag, ".write_enable"}, write_enable, exp_we);
        chk({tag, ".retired_count"}, retired_count, m_count);
        if (m_valid) begin
            chk({tag, ".wb_rd"}, wb_rd, m_rd);
            chk({tag, ".wb_data"}, wb_data, m_data);
            chk({tag, ".load_fault"}, load_fault, m_fault);
        end
    endtask

    task automatic drive(input bit v, input bit rw, input bit [4:0] rd, input bit [1:0] src,
                         input bit [2:0] f3, input bit [31:0] alu, input bit [31:0] rdata,
                         input bit [31:0] pc4);
        in_valid = v; in_reg_write = rw; in_rd = rd; in_result_src = src;
        in_funct3 = f3; in_alu_result = alu; in_mem_rdata = rdata; in_pc_plus4 = pc4;
    endtask

    typedef struct {
        string     name;
        bit [4:0]  rd;
        bit [1:0]  src;
        bit [2:0]  f3;
        bit [31:0] alu;
        bit [31:0] rdata;
        bit [31:0] pc4;
        bit [31:0] exp_data;
        bit        exp_we;
        bit        exp_fault;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"alu",      5'd5,  2'd0, 3'd0, 32'h1234_5678, 32'h0,         32'h0,   32'h1234_5678, 1, 0});
        vecs.push_back('{"lb_off3",  5'd3,  2'd1, 3'd0, 32'h0000_1003, 32'h80FF_7F01, 32'h0,   32'hFFFF_FF80, 1, 0});
        vecs.push_back('{"lbu_off3", 5'd3,  2'd1, 3'd4, 32'h0000_1003, 32'h80FF_7F01, 32'h0,   32'h0000_0080, 1, 0});
        vecs.push_back('{"lh_off2",  5'd4,  2'd1, 3'd1, 32'h0000_2002, 32'h80FF_7F01, 32'h0,   32'hFFFF_80FF, 1, 0});
        vecs.push_back('{"lhu_off0", 5'd6,  2'd1, 3'd5, 32'h0000_2000, 32'h80FF_7F01, 32'h0,   32'h0000_7F01, 1, 0});
        vecs.push_back('{"lw",       5'd8,  2'd1, 3'd2, 32'h0000_2000, 32'h80FF_7F01, 32'h0,   32'h80FF_7F01, 1, 0});
        vecs.push_back('{"ld_f011",  5'd9,  2'd1, 3'd3, 32'h0000_2000, 32'h80FF_7F01, 32'h0,   32'h0,         0, 1});
        vecs.push_back('{"x0_write", 5'd0,  2'd0, 3'd0, 32'hDEAD_BEEF, 32'h0,         32'h0,   32'hDEAD_BEEF, 0, 0});
        vecs.push_back('{"pc4",      5'd1,  2'd2, 3'd0, 32'h5555_0000, 32'h0,         32'h104, 32'h0000_0104, 1, 0});
        vecs.push_back('{"src11",    5'd2,  2'd3, 3'd0, 32'h5555_0000, 32'hFFFF_FFFF, 32'h104, 32'h0,         1, 0});
        vecs.push_back('{"lb_off1",  5'd10, 2'd1, 3'd0, 32'h0000_0001, 32'h80FF_7F01, 32'h0,   32'h0000_007F, 1, 0});
        vecs.push_back('{"lh_off3",  5'd11, 2'd1, 3'd1, 32'h0000_0003, 32'h80FF_7F01, 32'h0,   32'hFFFF_80FF, 1, 0});
        vecs.push_back('{"lhu_off1", 5'd12, 2'd1, 3'd5, 32'h0000_0001, 32'h80FF_7F01, 32'h0,   32'h0000_7F01, 1, 0});
        vecs.push_back('{"ld_f110",  5'd13, 2'd1, 3'd6, 32'h0000_0000, 32'h1234_5678, 32'h0,   32'h0,         0, 1});
        vecs.push_back('{"ld_f111",  5'd14, 2'd1, 3'd7, 32'h0000_0000, 32'h1234_5678, 32'h0,   32'h0,         0, 1});

        // ---------------- Reset ----------------
        rst_n = 0; stall = 0; flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        m_valid = 0; m_rw = 0; m_rd = 0; m_data = 0; m_fault = 0; m_count = 0;
        tick();
        tick();
        chk("reset.wb_valid", wb_valid, 0);
        chk("reset.write_enable", write_enable, 0);
        chk("reset.wb_rd", wb_rd, 0);
        chk("reset.wb_data", wb_data, 0);
        chk("reset.load_fault", load_fault, 0);
        chk("reset.retired_count", retired_count, 0);
        rst_n = 1;
        tick();
        chk("post_reset.wb_valid", wb_valid, 0);
        chk("post_reset.write_enable", write_enable, 0);

        // ---------------- Directed vector table ----------------
        foreach (vecs[i]) begin
            drive(1, 1, vecs[i].rd, vecs[i].src, vecs[i].f3, vecs[i].alu, vecs[i].rdata, vecs[i].pc4);
            tick();
            chk({vecs[i].name, ".wb_valid"}, wb_valid, 1);
            chk({vecs[i].name, ".wb_rd"}, wb_rd, vecs[i].rd);
            chk({vecs[i].name, ".wb_data"}, wb_data, vecs[i].exp_data);
            chk({vecs[i].name, ".write_enable"}, write_enable, vecs[i].exp_we);
            chk({vecs[i].name, ".load_fault"}, load_fault, vecs[i].exp_fault);
            chk({vecs[i].name, ".retired_count"}, retired_count, m_count);
        end

        // Bubble capture and reg_write=0
        drive(0, 1, 5'd9, 0, 0, 32'h1111_1111, 0, 0);
        tick();
        chk("bubble.wb_valid", wb_valid, 0);
        chk("bubble.write_enable", write_enable, 0);
        drive(1, 0, 5'd9, 0, 0, 32'h2222_2222, 0, 0);
        tick();
        chk("no_rw.write_enable", write_enable, 0);
        chk("no_rw.wb_valid", wb_valid, 1);

        // ---------------- Stall / flush ----------------
        drive(1, 1, 5'd7, 0, 0, 32'h0000_0777, 0, 0);
        tick();
        chk("stall_cap.wb_rd", wb_rd, 7);
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 5'(20 + k), 2'd2, 0, 32'hABCD_0000 + k, 0, 32'h900 + k);
            tick();
            chk("stall.wb_valid", wb_valid, 1);
            chk("stall.wb_rd", wb_rd, 7);
            chk("stall.wb_data", wb_data, 32'h777);
            chk("stall.write_enable", write_enable, 1);
            chk("stall.retired_count", retired_count, m_count);
        end
        flush = 1;
        tick();
        chk("flush_stall.wb_valid", wb_valid, 0);
        chk("flush_stall.write_enable", write_enable, 0);
        chk("flush_stall.load_fault", load_fault, 0);
        flush = 0;
        tick();
        chk("stall_bubble.wb_valid", wb_valid, 0);
        check_model("stall_bubble");
        stall = 0;

        // Flush of a faulting load clears the fault
        drive(1, 1, 5'd3, 2'd1, 3'd3, 0, 0, 0);
        tick();
        chk("fault_set.load_fault", load_fault, 1);
        flush = 1;
        tick();
        chk("fault_flush.load_fault", load_fault, 0);
        chk("fault_flush.wb_valid", wb_valid, 0);
        flush = 0;

        // ---------------- Counter wrap ----------------
        rst_n = 0;
        tick();
        chk("wrap_reset.retired_count", retired_count, 0);
        rst_n = 1;
        for (int k = 0; k < 16; k++) begin
            drive(1, 1, 5'd1, 0, 0, k, 0, 0);
            tick();
            chk("wrap.retired_count", retired_count, (k + 1) % 16);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 5'd1, 0, 0, k, 0, 0);
            tick();
        end
        chk("wrap_more.retired_count", retired_count, 3);
        // Reset during a stall discards the held instruction
        stall = 1;
        tick();
        rst_n = 0;
        tick();
        chk("stall_reset.wb_valid", wb_valid, 0);
        chk("stall_reset.retired_count", retired_count, 0);
        chk("stall_reset.wb_data", wb_data, 0);
        rst_n = 1; stall = 0;

        // ---------------- Randomized traffic ----------------
        for (int k = 0; k < 400; k++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                  2'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
            tick();
            check_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
